// File: rtl/user_pcie_req_arbiter_if.sv
// user_pcie_req_arbiter_if: channel-side request/data buses and Tx engine request interface.
// The master modport is the arbiter's view; the slave modport is the channels plus Tx engine.
interface user_pcie_req_arbiter_if #(parameter int NUM_CH = 4);
  logic [NUM_CH-1:0]    dma_rd_req_i;
  logic [12*NUM_CH-1:0] dma_rd_req_len_i;
  logic [32*NUM_CH-1:0] dma_rd_req_addr_i;
  logic [8*NUM_CH-1:0]  dma_tag_i;
  logic [NUM_CH-1:0]    dma_req_ack_o;
  logic [NUM_CH-1:0]    user_stream_data_avail_i;
  logic [5*NUM_CH-1:0]  user_stream_data_len_i;
  logic [32*NUM_CH-1:0] user_stream_wr_addr_i;
  logic [64*NUM_CH-1:0] user_stream_data_i;
  logic [NUM_CH-1:0]    user_stream_data_rd_o;
  logic [NUM_CH-1:0]    user_stream_wr_ack_o;
  logic                 tx_rd_req_o;
  logic                 tx_rd_req_ack_i;
  logic [11:0]          tx_rd_req_len_o;
  logic [31:0]          tx_rd_req_addr_o;
  logic [7:0]           tx_rd_tag_o;
  logic                 tx_wr_req_o;
  logic                 tx_wr_req_ack_i;
  logic [4:0]           tx_wr_len_o;
  logic [31:0]          tx_wr_addr_o;
  logic [63:0]          tx_wr_data_o;
  logic                 tx_wr_data_rd_i;
  modport master (
    input  dma_rd_req_i, dma_rd_req_len_i, dma_rd_req_addr_i, dma_tag_i,
    input  user_stream_data_avail_i, user_stream_data_len_i, user_stream_wr_addr_i, user_stream_data_i,
    input  tx_rd_req_ack_i, tx_wr_req_ack_i, tx_wr_data_rd_i,
    output dma_req_ack_o, user_stream_data_rd_o, user_stream_wr_ack_o,
    output tx_rd_req_o, tx_rd_req_len_o, tx_rd_req_addr_o, tx_rd_tag_o,
    output tx_wr_req_o, tx_wr_len_o, tx_wr_addr_o, tx_wr_data_o
  );
  modport slave (
    output dma_rd_req_i, dma_rd_req_len_i, dma_rd_req_addr_i, dma_tag_i,
    output user_stream_data_avail_i, user_stream_data_len_i, user_stream_wr_addr_i, user_stream_data_i,
    output tx_rd_req_ack_i, tx_wr_req_ack_i, tx_wr_data_rd_i,
    input  dma_req_ack_o, user_stream_data_rd_o, user_stream_wr_ack_o,
    input  tx_rd_req_o, tx_rd_req_len_o, tx_rd_req_addr_o, tx_rd_tag_o,
    input  tx_wr_req_o, tx_wr_len_o, tx_wr_addr_o, tx_wr_data_o
  );
endinterface

// File: rtl/user_pcie_req_arbiter.sv
// user_pcie_req_arbiter: two-class (read/write) alternating, per-class round-robin arbiter
// that forwards one channel's request at a time to the PCIe Tx engine.
module user_pcie_req_arbiter #(
  parameter int NUM_CH = 4
) (
  input logic clk_i,
  input logic rst_n,
  user_pcie_req_arbiter_if.master bus
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic [1:0] {IDLE, RD_GRANT, WR_GRANT, COOLDOWN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] gnt_q, gnt_d, rr_rd_q, rr_rd_d, rr_wr_q, rr_wr_d, rd_idx, wr_idx;
  logic last_wr_q, last_wr_d, rd_any, wr_any, pick_wr;
  logic tx_rd_req_q, tx_rd_req_d, tx_wr_req_q, tx_wr_req_d;
  logic [11:0] rd_len_q, rd_len_d;
  logic [31:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [7:0] rd_tag_q, rd_tag_d;
  logic [4:0] wr_len_q, wr_len_d, wr_len_in;
  logic [NUM_CH-1:0] rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d;
  // First requester strictly after the last-served channel, wrapping around.
  function automatic logic [CW-1:0] rr_pick(input logic [NUM_CH-1:0] req, input logic [CW-1:0] rr);
    logic [CW-1:0] i;
    rr_pick = rr;
    for (int k = NUM_CH; k >= 1; k--) begin
      i = CW'((int'(rr) + k) % NUM_CH);
      if (req[i]) rr_pick = i;
    end
  endfunction
  assign rd_any = |bus.dma_rd_req_i;
  assign wr_any = |bus.user_stream_data_avail_i;
  assign rd_idx = rr_pick(bus.dma_rd_req_i, rr_rd_q);
  assign wr_idx = rr_pick(bus.user_stream_data_avail_i, rr_wr_q);
  assign pick_wr = wr_any && (!rd_any || !last_wr_q);
  assign wr_len_in = bus.user_stream_data_len_i[5*wr_idx +: 5];
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    rr_rd_d = rr_rd_q;
    rr_wr_d = rr_wr_q;
    last_wr_d = last_wr_q;
    tx_rd_req_d = tx_rd_req_q;
    tx_wr_req_d = tx_wr_req_q;
    rd_len_d = rd_len_q;
    rd_addr_d = rd_addr_q;
    rd_tag_d = rd_tag_q;
    wr_len_d = wr_len_q;
    wr_addr_d = wr_addr_q;
    rd_ack_d = rd_ack_q;
    wr_ack_d = wr_ack_q;
    case (state_q)
      IDLE: if (rd_any || wr_any) begin
        last_wr_d = pick_wr;
        if (pick_wr) begin
          gnt_d = wr_idx;
          rr_wr_d = wr_idx;
          wr_len_d = wr_len_in;
          wr_addr_d = bus.user_stream_wr_addr_i[32*wr_idx +: 32];
          // An empty write has nothing to send; acknowledge it locally.
          if (wr_len_in == 5'd0) begin
            wr_ack_d[wr_idx] = 1'b1;
            state_d = COOLDOWN;
          end else begin
            tx_wr_req_d = 1'b1;
            state_d = WR_GRANT;
          end
        end else begin
          gnt_d = rd_idx;
          rr_rd_d = rd_idx;
          rd_len_d = bus.dma_rd_req_len_i[12*rd_idx +: 12];
          rd_addr_d = bus.dma_rd_req_addr_i[32*rd_idx +: 32];
          rd_tag_d = bus.dma_tag_i[8*rd_idx +: 8];
          tx_rd_req_d = 1'b1;
          state_d = RD_GRANT;
        end
      end
      RD_GRANT: if (bus.tx_rd_req_ack_i) begin
        tx_rd_req_d = 1'b0;
        rd_ack_d[gnt_q] = 1'b1;
        state_d = COOLDOWN;
      end
      WR_GRANT: if (bus.tx_wr_req_ack_i) begin
        tx_wr_req_d = 1'b0;
        wr_ack_d[gnt_q] = 1'b1;
        state_d = COOLDOWN;
      end
      // Lets the acked channel drop its request before arbitration resumes.
      COOLDOWN: begin
        rd_ack_d = '0;
        wr_ack_d = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      rr_rd_q <= '0;
      rr_wr_q <= '0;
      last_wr_q <= 1'b1;
      tx_rd_req_q <= 1'b0;
      tx_wr_req_q <= 1'b0;
      rd_len_q <= '0;
      rd_addr_q <= '0;
      rd_tag_q <= '0;
      wr_len_q <= '0;
      wr_addr_q <= '0;
      rd_ack_q <= '0;
      wr_ack_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      rr_rd_q <= rr_rd_d;
      rr_wr_q <= rr_wr_d;
      last_wr_q <= last_wr_d;
      tx_rd_req_q <= tx_rd_req_d;
      tx_wr_req_q <= tx_wr_req_d;
      rd_len_q <= rd_len_d;
      rd_addr_q <= rd_addr_d;
      rd_tag_q <= rd_tag_d;
      wr_len_q <= wr_len_d;
      wr_addr_q <= wr_addr_d;
      rd_ack_q <= rd_ack_d;
      wr_ack_q <= wr_ack_d;
    end
  end
  assign bus.tx_rd_req_o = tx_rd_req_q;
  assign bus.tx_rd_req_len_o = rd_len_q;
  assign bus.tx_rd_req_addr_o = rd_addr_q;
  assign bus.tx_rd_tag_o = rd_tag_q;
  assign bus.tx_wr_req_o = tx_wr_req_q;
  assign bus.tx_wr_len_o = wr_len_q;
  assign bus.tx_wr_addr_o = wr_addr_q;
  assign bus.dma_req_ack_o = rd_ack_q;
  assign bus.user_stream_wr_ack_o = wr_ack_q;
  assign bus.user_stream_data_rd_o = (state_q == WR_GRANT && bus.tx_wr_data_rd_i) ? NUM_CH'(1) << gnt_q : '0;
  assign bus.tx_wr_data_o = state_q == WR_GRANT ? bus.user_stream_data_i[64*gnt_q +: 64] : '0;
endmodule
